// File: rtl/twiddle_addr_sequencer_if.sv
// Run-control handshake and twiddle-ROM request bundle for twiddle_addr_sequencer.
// The slave side is the sequencer; the master side is the run controller / bridge.
interface twiddle_addr_sequencer_if #(
    parameter int FFT_N = 10
);
    localparam int SW = $clog2(FFT_N);

    logic             start;
    logic             ifft_in;
    logic             stall;
    logic             busy;
    logic             done;
    logic             tact_rom;
    logic [FFT_N-2:0] ta_rom;
    logic             evenOdd;
    logic             ifft;
    logic [SW-1:0]    stage;
    logic [FFT_N-2:0] bfly;
    logic             tw_valid;

    modport slave (
        input  start, ifft_in, stall,
        output busy, done, tact_rom, ta_rom, evenOdd, ifft, stage, bfly, tw_valid
    );

    modport master (
        output start, ifft_in, stall,
        input  busy, done, tact_rom, ta_rom, evenOdd, ifft, stage, bfly, tw_valid
    );
endinterface

// File: rtl/twiddle_addr_sequencer.sv
// Walks all stages/butterflies of a radix-2 FFT run and issues twiddle ROM reads,
// with tw_valid tracking the bridge's fixed read latency.
module twiddle_addr_sequencer #(
    parameter int FFT_N   = 10,
    parameter int ROM_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    twiddle_addr_sequencer_if.slave  bus
);
    localparam int W  = FFT_N - 1;
    localparam int SW = $clog2(FFT_N);

    localparam logic [W-1:0]       J_MAX   = {W{1'b1}};
    localparam logic [SW-1:0]      S_MAX   = SW'(FFT_N - 1);
    localparam logic [ROM_LAT-1:0] SR_LAST = ROM_LAT'(1) << (ROM_LAT - 1);

    typedef enum logic [1:0] {IDLE, EVEN, ODD, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [SW-1:0]      s, s_nxt;
    logic [W-1:0]       j, j_nxt;
    logic               ifft_q, ifft_nxt;
    logic [ROM_LAT-1:0] rd_sr;
    logic [W-1:0]       tw_idx;
    logic               rd_issue;
    logic               drain_last;

    // k = (j mod 2**s) << (FFT_N-1-s); the shifted-out mask is all ones at the last stage.
    assign tw_idx   = (j & ~(J_MAX << s)) << (S_MAX - s);
    assign rd_issue = (state == EVEN) && !bus.stall;

    // Nothing left in flight except possibly the read now at the output. This also
    // ends DRAIN cleanly if a long stall in the final ODD let the last read emerge early.
    assign drain_last = (rd_sr & ~SR_LAST) == '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            s      <= '0;
            j      <= '0;
            ifft_q <= 1'b0;
            rd_sr  <= '0;
        end else begin
            state  <= state_nxt;
            s      <= s_nxt;
            j      <= j_nxt;
            ifft_q <= ifft_nxt;
            rd_sr  <= (rd_sr << 1) | ROM_LAT'(rd_issue);
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        j_nxt     = j;
        ifft_nxt  = ifft_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = EVEN;
                    s_nxt     = '0;
                    j_nxt     = '0;
                    ifft_nxt  = bus.ifft_in;
                end
            end
            EVEN: begin
                if (!bus.stall) state_nxt = ODD;
            end
            ODD: begin
                if (!bus.stall) begin
                    if (j != J_MAX) begin
                        j_nxt     = j + 1'b1;
                        state_nxt = EVEN;
                    end else if (s != S_MAX) begin
                        j_nxt     = '0;
                        s_nxt     = s + 1'b1;
                        state_nxt = EVEN;
                    end else begin
                        j_nxt     = '0;
                        s_nxt     = '0;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state != IDLE);
        bus.tact_rom = 1'b0;
        bus.evenOdd  = 1'b0;
        bus.ta_rom   = '0;
        bus.done     = 1'b0;
        unique case (state)
            EVEN: begin
                bus.tact_rom = !bus.stall;
                bus.ta_rom   = tw_idx;
            end
            ODD: begin
                bus.tact_rom = !bus.stall;
                bus.evenOdd  = 1'b1;
                bus.ta_rom   = tw_idx;
            end
            DRAIN:   bus.done = drain_last;
            default: ;
        endcase
    end

    assign bus.ifft     = ifft_q;
    assign bus.stage    = s;
    assign bus.bfly     = j;
    assign bus.tw_valid = rd_sr[ROM_LAT-1];
endmodule

// File: tb/tb_twiddle_addr_sequencer.sv
// Directed bench for twiddle_addr_sequencer at FFT_N=4, ROM_LAT=3.
module tb_twiddle_addr_sequencer;
    localparam int FFT_N   = 4;
    localparam int ROM_LAT = 3;
    localparam int N_RD    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    twiddle_addr_sequencer_if #(.FFT_N(FFT_N)) bus ();

    twiddle_addr_sequencer #(.FFT_N(FFT_N), .ROM_LAT(ROM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Expected ta_rom per read, stage by stage, hand-derived.
    int exp_addr [N_RD] = '{0, 0, 0, 0, 0, 0, 0, 0,
                            0, 4, 0, 4, 0, 4, 0, 4,
                            0, 2, 4, 6, 0, 2, 4, 6,
                            0, 1, 2, 3, 4, 5, 6, 7};

    int       n_reads, n_tw, done_at, idle_at, first_even, last_even, ifft_bad;
    logic     done_tw;
    logic [2:0] addr_log [N_RD];

    // One run: start in cycle 0, observe each cycle at negedge+1 until busy drops.
    task automatic run_one(input logic dir, input int st_s, input int st_j,
                           input int st_n, input bit poke);
        int stall_left;
        bit stall_used;
        n_reads = 0; n_tw = 0; done_at = -1; idle_at = -1;
        first_even = -1; last_even = -1; ifft_bad = 0; done_tw = 1'b0;
        stall_left = 0; stall_used = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.ifft_in = dir; bus.stall = 1'b0;
        for (int c = 1; c <= 400 && idle_at < 0; c++) begin
            @(negedge clk);
            bus.start   = (poke && c == 10);
            bus.ifft_in = poke ? ~dir : dir;
            if (!stall_used && st_n > 0 && bus.busy && !bus.evenOdd &&
                int'(bus.stage) == st_s && int'(bus.bfly) == st_j) begin
                stall_left = st_n;
                stall_used = 1'b1;
            end
            bus.stall = (stall_left > 0);
            #1;
            if (stall_left > 0) begin
                stall_left--;
                checks++;
                if (bus.tact_rom !== 1'b0 || bus.ta_rom !== 3'(exp_addr[st_s*8+st_j])) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d tact_rom=%b ta_rom=%0d, want 0 and %0d",
                             c, bus.tact_rom, bus.ta_rom, exp_addr[st_s*8+st_j]);
                end
            end
            if (!bus.busy) begin
                idle_at = c;
            end else begin
                if (bus.ifft !== dir) ifft_bad++;
                if (bus.tact_rom && !bus.evenOdd) begin
                    if (n_reads < N_RD) addr_log[n_reads] = bus.ta_rom;
                    n_reads++;
                    last_even = c;
                    if (first_even < 0) first_even = c;
                end
                if (bus.tw_valid) n_tw++;
                if (bus.done) begin
                    done_at = c;
                    done_tw = bus.tw_valid;
                    if (poke) bus.start = 1'b1;
                end
            end
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        if (idle_at < 0) begin
            checks++; errors++;
            $display("FAIL run_timeout busy never fell within 400 cycles");
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b1; bus.ifft_in = 1'b1; bus.stall = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.tact_rom, bus.ta_rom, bus.evenOdd, bus.ifft,
             bus.stage, bus.bfly, bus.tw_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b tact=%b ta=%0d eo=%b ifft=%b s=%0d j=%0d tv=%b, want all 0",
                     bus.busy, bus.done, bus.tact_rom, bus.ta_rom, bus.evenOdd, bus.ifft,
                     bus.stage, bus.bfly, bus.tw_valid);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_full_run;
        run_one(1'b0, -1, -1, 0, 1'b0);
        checks++;
        if (first_even != 1 || last_even != 63) begin
            errors++;
            $display("FAIL run_even_window first=%0d last=%0d, want 1 and 63", first_even, last_even);
        end
        checks++;
        if (n_reads != N_RD || n_tw != N_RD) begin
            errors++;
            $display("FAIL run_counts reads=%0d tw_valid=%0d, want 32 and 32", n_reads, n_tw);
        end
        checks++;
        if (done_at != 66 || done_tw !== 1'b1) begin
            errors++;
            $display("FAIL run_done cyc=%0d tw_valid=%b, want 66 and 1", done_at, done_tw);
        end
        checks++;
        if (idle_at != 67) begin
            errors++;
            $display("FAIL run_busy_fall cyc=%0d, want 67", idle_at);
        end
        for (int i = 0; i < N_RD; i++) begin
            checks++;
            if (addr_log[i] !== 3'(exp_addr[i])) begin
                errors++;
                $display("FAIL addr read=%0d ta_rom=%0d, want %0d", i, addr_log[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_stall;
        run_one(1'b0, 2, 3, 5, 1'b0);
        checks++;
        if (done_at != 71 || idle_at != 72) begin
            errors++;
            $display("FAIL stall_done done=%0d idle=%0d, want 71 and 72", done_at, idle_at);
        end
        checks++;
        if (n_reads != N_RD || n_tw != N_RD) begin
            errors++;
            $display("FAIL stall_counts reads=%0d tw_valid=%0d, want 32 and 32", n_reads, n_tw);
        end
        checks++;
        if (addr_log[19] !== 3'd6 || addr_log[20] !== 3'd0) begin
            errors++;
            $display("FAIL stall_addr r19=%0d r20=%0d, want 6 and 0", addr_log[19], addr_log[20]);
        end
    endtask

    task automatic test_start_ignored;
        run_one(1'b0, -1, -1, 0, 1'b1);
        checks++;
        if (ifft_bad != 0) begin
            errors++;
            $display("FAIL ignore_ifft changed in %0d cycles, want 0", ifft_bad);
        end
        checks++;
        if (done_at != 66 || n_reads != N_RD) begin
            errors++;
            $display("FAIL ignore_restart done=%0d reads=%0d, want 66 and 32", done_at, n_reads);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_at_done busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int  bad;
        bit  found;
        found = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.ifft_in = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.busy && !bus.evenOdd && bus.stage == 2'd1 && bus.bfly == 3'd5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrst_reach s=1 j=5 not observed, stage=%0d bfly=%0d", bus.stage, bus.bfly);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.tact_rom, bus.ta_rom, bus.evenOdd, bus.ifft,
             bus.stage, bus.bfly, bus.tw_valid} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs busy=%b done=%b tact=%b ta=%0d eo=%b ifft=%b s=%0d j=%0d tv=%b, want all 0",
                     bus.busy, bus.done, bus.tact_rom, bus.ta_rom, bus.evenOdd, bus.ifft,
                     bus.stage, bus.bfly, bus.tw_valid);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (bus.tw_valid || bus.done || bus.busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_quiet activity in %0d cycles, want 0", bad);
        end
        run_one(1'b0, -1, -1, 0, 1'b0);
        checks++;
        if (first_even != 1 || n_reads != N_RD || done_at != 66) begin
            errors++;
            $display("FAIL midrst_rerun first=%0d reads=%0d done=%0d, want 1 32 66",
                     first_even, n_reads, done_at);
        end
        bad = 0;
        for (int i = 0; i < N_RD; i++) if (addr_log[i] !== 3'(exp_addr[i])) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_addr %0d wrong addresses, want 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        run_one(1'b1, -1, -1, 0, 1'b0);
        checks++;
        if (ifft_bad != 0 || done_at != 66) begin
            errors++;
            $display("FAIL b2b_first ifft_bad=%0d done=%0d, want 0 and 66", ifft_bad, done_at);
        end
        checks++;
        if (bus.ifft !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ifft_hold ifft=%b, want 1", bus.ifft);
        end
        run_one(1'b0, -1, -1, 0, 1'b0);
        checks++;
        if (ifft_bad != 0 || done_at != 66 || n_tw != N_RD) begin
            errors++;
            $display("FAIL b2b_second ifft_bad=%0d done=%0d tw=%0d, want 0 66 32",
                     ifft_bad, done_at, n_tw);
        end
        checks++;
        if (bus.ifft !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ifft_final ifft=%b, want 0", bus.ifft);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.ifft_in = 1'b0; bus.stall = 1'b0;
        test_reset();
        test_full_run();
        test_stall();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
